uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_rx.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver slice.
// Holds the receiver FSM state type, the default clock/baud/oversampling
// constants and the baud divisor calculation used by uart_rx and uart_baud_tick.
package uart_pkg;

    localparam int DEF_CLK_HZ = 100_000_000;
    localparam int DEF_BAUD   = 9600;
    localparam int DEF_OVS    = 16;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Rounded clocks per oversampling tick; never below one clock.
    function automatic int calc_divisor(input int clk_hz, input int baud, input int ovs);
        int den;
        int div;
        den = baud * ovs;
        div = (clk_hz + den / 2) / den;
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversampling tick generator.
// Produces a one-clock tick every DIVISOR clocks; restart re-phases the
// counter to zero so that tick timing is measured from the frame start.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIVISOR = calc_divisor(DEF_CLK_HZ, DEF_BAUD, DEF_OVS)
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap at the divisor, or snap to zero on a frame start.
    always_comb begin
        if (restart || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver (8N1, LSB first, idle high).
// Each bit is decided by a 3-sample majority vote around the bit centre.
// Optional feature: define UART_RX_PARITY_EN to receive one even-parity bit
// after D7 (8E1); otherwise the PARITY state is unreachable and parity_err is 0.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ,
    parameter int BAUD   = DEF_BAUD,
    parameter int OVS    = DEF_OVS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int DIVISOR = calc_divisor(CLK_HZ, BAUD, OVS);
    localparam int TW      = (OVS > 1) ? $clog2(OVS) : 1;

    // Sample points: the three ticks around the centre (7, 8, 9 for OVS=16).
    localparam logic [TW-1:0] TICK_S0   = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TICK_S1   = TW'(OVS / 2);
    localparam logic [TW-1:0] TICK_VOTE = TW'(OVS / 2 + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    // Synchronizer and edge detection.
    logic            rx_meta_q, rx_meta_d;
    logic            rx_s_q, rx_s_d;
    logic            rx_prev_q, rx_prev_d;
    logic [1:0]      settle_q, settle_d;

    // Frame state.
    rx_state_e       state_q, state_d;
    logic [TW-1:0]   tick_idx_q, tick_idx_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [1:0]      vote_q, vote_d;

    // Registered outputs.
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;

`ifdef UART_RX_PARITY_EN
    logic            parity_bad_q, parity_bad_d;
    logic            parity_err_q, parity_err_d;
`endif

    logic            tick;
    logic            fall;
    logic            frame_start;
    logic            vote_now;
    logic            vote;
    logic            deliver;
    logic            parity_ok;

    uart_baud_tick #(
        .DIVISOR (DIVISOR)
    ) u_baud_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (frame_start),
        .tick    (tick)
    );

    // A falling edge only counts once rx_prev holds a genuinely sampled high,
    // so the reset value of the synchronizer cannot fake a start bit.
    assign fall        = rx_prev_q & ~rx_s_q;
    assign frame_start = (state_q == IDLE) && fall;
    assign vote_now    = tick && (state_q != IDLE) && (tick_idx_q == TICK_VOTE);
    assign vote        = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);

`ifdef UART_RX_PARITY_EN
    assign parity_ok   = ~parity_bad_q;
`else
    assign parity_ok   = 1'b1;
`endif

    // Next-state, datapath and output decode for the whole receiver.
    always_comb begin
        // NOTE: every _d is first given a default so no branch leaves it unassigned and infers a latch.
        rx_meta_d   = RX;
        rx_s_d      = rx_meta_q;
        settle_d    = {settle_q[0], 1'b1};
        rx_prev_d   = settle_q[1] & rx_s_q;
        state_d     = state_q;
        tick_idx_d  = tick_idx_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        vote_d      = vote_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
        parity_err_d = 1'b0;
`endif

        // Tick position within the current bit and the two early samples.
        if ((state_q != IDLE) && tick) begin
            tick_idx_d = (tick_idx_q == TICK_LAST) ? '0 : tick_idx_q + 1'b1;
            if (tick_idx_q == TICK_S0) vote_d[0] = rx_s_q;
            if (tick_idx_q == TICK_S1) vote_d[1] = rx_s_q;
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d    = START;
                    tick_idx_d = '0;
                    bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                    parity_bad_d = 1'b0;
`endif
                end
            end
            START: begin
                if (vote_now) begin
                    state_d = vote ? IDLE : DATA;
                end
            end
            DATA: begin
                if (vote_now) begin
                    shift_d   = {vote, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (vote_now) begin
                    state_d = STOP;
                    if (vote != ^shift_q) begin
                        parity_err_d = 1'b1;
                        parity_bad_d = 1'b1;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (vote_now) begin
                    state_d = IDLE;
                    if (vote) begin
                        deliver = parity_ok;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Host handshake: a read clears valid; a delivery into an unread
        // buffer is dropped unless the read happens in the same cycle.
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (deliver) begin
            if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b0;
            settle_q    <= '0;
            state_q     <= IDLE;
            tick_idx_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            vote_q      <= '0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            rx_prev_q   <= rx_prev_d;
            settle_q    <= settle_d;
            state_q     <= state_d;
            tick_idx_q  <= tick_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            vote_q      <= vote_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a frame-level reference model.
// The clock is scaled so one tick is 4 clocks and one bit 64 clocks.
// Honours UART_RX_PARITY_EN for the frame format and the parity scenarios.
module tb_uart_rx;

    localparam int BAUD     = 9600;
    localparam int OVS      = 16;
    localparam int DIV      = 4;
    localparam int CLK_HZ   = BAUD * OVS * DIV;
    localparam int BIT_CLKS = DIV * OVS;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NBITS = PAR ? 11 : 10;

    localparam int EV_BYTE = 0;
    localparam int EV_FERR = 1;
    localparam int EV_PERR = 2;

    typedef struct {
        int         at;
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       RX;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   fe_cnt = 0;
    int   ov_cnt = 0;
    int   pe_cnt = 0;
    int   last_e0 = 0;
    int   deliv_target = 0;
    bit   model_live = 1'b0;
    ev_t  ev_q[$];

    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_fe;
    logic       exp_ov;
    logic       exp_pe;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .OVS    (OVS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .RX         (RX),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Edge on which the outputs reflect the vote of line bit b. The line fall
    // reaches rx_s after two edges and restarts the tick counter on the next;
    // the vote uses tick OVS*b + OVS/2 + 1 (0-based), and tick k lands
    // DIV*(k+1) edges after the restart.
    function automatic int vote_edge(input int e0, input int b);
        return e0 + 2 + DIV * (OVS * b + OVS / 2 + 2);
    endfunction

    // Reference model: applies expected frame outcomes and the read rules.
    initial begin
        ev_t ev;
        bit  got;
        logic [7:0] nb;
        forever begin
            @(posedge clk);
            cyc++;
            exp_fe = 1'b0;
            exp_ov = 1'b0;
            exp_pe = 1'b0;
            if (reset) begin
                model_live = 1'b1;
                exp_data   = 8'h00;
                exp_valid  = 1'b0;
                ev_q.delete();
            end else begin
                got = 1'b0;
                nb  = 8'h00;
                while (ev_q.size() > 0 && ev_q[0].at == cyc) begin
                    ev = ev_q.pop_front();
                    if (ev.kind == EV_BYTE) begin
                        got = 1'b1;
                        nb  = ev.data;
                    end else if (ev.kind == EV_FERR) begin
                        exp_fe = 1'b1;
                    end else begin
                        exp_pe = 1'b1;
                    end
                end
                if (got) begin
                    if (exp_valid && !rx_ready) begin
                        exp_ov = 1'b1;
                    end else begin
                        exp_data  = nb;
                        exp_valid = 1'b1;
                    end
                end else if (exp_valid && rx_ready) begin
                    exp_valid = 1'b0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison and pulse counting, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                check("rx_data", rx_data, exp_data);
                check("rx_valid", rx_valid, exp_valid);
                check("frame_err", frame_err, exp_fe);
                check("overrun", overrun, exp_ov);
                check("parity_err", parity_err, exp_pe);
            end
            if (frame_err === 1'b1) fe_cnt++;
            if (overrun === 1'b1) ov_cnt++;
            if (parity_err === 1'b1) pe_cnt++;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    // Drives one frame and records what the receiver must do with it.
    task automatic send_frame(input logic [7:0] data, input logic par_bit, input logic stop_bit);
        logic [10:0] line;
        ev_t         ev;
        bit          bad;
        int          e0;
        line    = '1;
        line[0] = 1'b0;
        for (int i = 0; i < 8; i++) line[i + 1] = data[i];
        if (PAR) line[9] = par_bit;
        line[NBITS - 1] = stop_bit;
        @(negedge clk);
        e0      = cyc + 1;
        last_e0 = e0;
        bad     = 1'b0;
        if (PAR && (par_bit != ^data)) begin
            bad     = 1'b1;
            ev.at   = vote_edge(e0, 9);
            ev.kind = EV_PERR;
            ev.data = data;
            ev_q.push_back(ev);
        end
        ev.at = vote_edge(e0, NBITS - 1);
        deliv_target = ev.at;
        ev.data = data;
        if (!stop_bit) begin
            ev.kind = EV_FERR;
            ev_q.push_back(ev);
        end else if (!bad) begin
            ev.kind = EV_BYTE;
            ev_q.push_back(ev);
        end
        for (int i = 0; i < NBITS; i++) begin
            RX = line[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    task automatic pulse_ready();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        RX       = 1'b1;
        rx_ready = 1'b0;
        reset    = 1'b1;
        idle(3);
        reset = 1'b0;
        check("reset_data", rx_data, 8'h00);
        check("reset_valid", rx_valid, 1'b0);
        check("reset_pulses", {frame_err, overrun, parity_err}, 3'b000);
        idle(20);

        // Plain reception of 0xD2.
        send_frame(8'hD2, 1'b0, 1'b1);
        check("d2_data", rx_data, 8'hD2);
        check("d2_valid", rx_valid, 1'b1);
        check("d2_no_err", fe_cnt + ov_cnt + pe_cnt, 0);

        // 0xAF arrives while 0xD2 is unread: dropped with overrun.
        send_frame(8'hAF, 1'b0, 1'b1);
        check("ovr_data_kept", rx_data, 8'hD2);
        check("ovr_count", ov_cnt, 1);

        // Read first, then 0xAF is accepted.
        pulse_ready();
        check("read_clears", rx_valid, 1'b0);
        pulse_ready();
        check("ready_ignored", rx_valid, 1'b0);
        send_frame(8'hAF, 1'b0, 1'b1);
        check("af_data", rx_data, 8'hAF);

        // Read in the very cycle 0x96 is delivered: loads, no overrun.
        deliv_target = 0;
        fork
            send_frame(8'h96, 1'b0, 1'b1);
            begin
                idle(2);
                while (cyc + 1 < deliv_target) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        check("same_cycle_data", rx_data, 8'h96);
        check("same_cycle_valid", rx_valid, 1'b1);
        check("same_cycle_no_ovr", ov_cnt, 1);

        // 0x12 with a low stop bit; line stays low, then a good 0x12.
        pulse_ready();
        send_frame(8'h12, 1'b0, 1'b0);
        idle(2 * BIT_CLKS);
        check("ferr_count", fe_cnt, 1);
        check("ferr_no_valid", rx_valid, 1'b0);
        check("ferr_data_kept", rx_data, 8'h96);
        RX = 1'b1;
        idle(BIT_CLKS);
        send_frame(8'h12, 1'b0, 1'b1);
        check("after_ferr_data", rx_data, 8'h12);
        check("after_ferr_valid", rx_valid, 1'b1);

        // Short low glitch, then 0x5A.
        pulse_ready();
        idle(10);
        RX = 1'b0;
        idle(3);
        RX = 1'b1;
        idle(2 * BIT_CLKS);
        check("glitch_valid", rx_valid, 1'b0);
        check("glitch_data", rx_data, 8'h12);
        check("glitch_pulses", fe_cnt + pe_cnt, 1);
        send_frame(8'h5A, 1'b0, 1'b1);
        check("5a_data", rx_data, 8'h5A);

        // Reset during D4 of 0x0F (line low from D4 on), then 0x3C.
        fork
            send_frame(8'h0F, ^8'h0F, 1'b1);
            begin
                idle(2);
                while (cyc < last_e0 + 5 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
                reset = 1'b1;
                idle(2);
                reset = 1'b0;
                check("midrst_data", rx_data, 8'h00);
                check("midrst_valid", rx_valid, 1'b0);
            end
        join
        idle(3 * BIT_CLKS);
        check("midrst_no_byte", rx_valid, 1'b0);
        send_frame(8'h3C, ^8'h3C, 1'b1);
        check("3c_data", rx_data, 8'h3C);
        check("3c_valid", rx_valid, 1'b1);

`ifdef UART_RX_PARITY_EN
        // 0xD2 has four ones: even parity bit must be 0.
        pulse_ready();
        send_frame(8'hD2, 1'b1, 1'b1);
        check("perr_count", pe_cnt, 1);
        check("perr_no_valid", rx_valid, 1'b0);
        send_frame(8'hD2, 1'b0, 1'b1);
        check("par_ok_data", rx_data, 8'hD2);
        check("par_ok_valid", rx_valid, 1'b1);
`else
        check("no_parity_pulses", pe_cnt, 0);
`endif

        idle(20);
        check("events_consumed", ev_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
